// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// The controller side (master) samples opcode/mem_ready and drives every strobe and select.
interface multicycle_control_if;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_cond;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        i_or_d;
    logic        mem_to_reg;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_source;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] retired_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal, state, retired_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               illegal, state, retired_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style main controller: Moore FSM driving datapath strobes,
// with a retired-instruction counter.
//
// state     | meaning
// FETCH     | read instruction, PC+4; waits on mem_ready
// DECODE    | latch opcode class, branch target into ALUOut
// MEM_ADDR  | rs1 + imm address for load/store
// MEM_READ  | data read; waits on mem_ready
// MEM_WB    | load data into register file
// MEM_WRITE | data write; waits on mem_ready
// EXECUTE   | R-type ALU operation
// ALU_WB    | ALU result into register file
// BRANCH    | compare and conditional PC update
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE, CLS_LOAD, CLS_STORE, CLS_RTYPE, CLS_BRANCH
    } cls_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state_q, state_d;
    cls_t        cls_q, cls_dec;
    logic [31:0] count_q;
    logic        retire;
    logic        pc_write_r, pc_write_cond_r, ir_write_r, mem_write_r, reg_write_r, illegal_r;

    always_comb begin
        unique case (bus.opcode)
            OP_LOAD:   cls_dec = CLS_LOAD;
            OP_STORE:  cls_dec = CLS_STORE;
            OP_RTYPE:  cls_dec = CLS_RTYPE;
            OP_BRANCH: cls_dec = CLS_BRANCH;
            default:   cls_dec = CLS_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_NONE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                cls_q <= cls_dec;
            if (retire)
                count_q <= count_q + 32'd1;
        end
    end

    always_comb begin
        state_d          = S_FETCH;
        retire           = 1'b0;
        pc_write_r       = 1'b0;
        pc_write_cond_r  = 1'b0;
        ir_write_r       = 1'b0;
        mem_write_r      = 1'b0;
        reg_write_r      = 1'b0;
        illegal_r        = 1'b0;
        bus.mem_read     = 1'b0;
        bus.i_or_d       = 1'b0;
        bus.mem_to_reg   = 1'b0;
        bus.alu_src_a    = 2'b00;
        bus.alu_src_b    = 2'b00;
        bus.alu_op       = 2'b00;
        bus.pc_source    = 2'b00;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                ir_write_r    = bus.mem_ready;
                pc_write_r    = bus.mem_ready;
                state_d       = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b10;
                unique case (cls_dec)
                    CLS_LOAD, CLS_STORE: state_d = S_MEM_ADDR;
                    CLS_RTYPE:           state_d = S_EXECUTE;
                    CLS_BRANCH:          state_d = S_BRANCH;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_r = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                state_d       = (cls_q == CLS_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                state_d      = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write_r    = 1'b1;
                bus.mem_to_reg = 1'b1;
                retire         = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.i_or_d  = 1'b1;
                mem_write_r = 1'b1;
                retire      = bus.mem_ready;
                state_d     = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_op    = 2'b10;
                state_d       = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_r = 1'b1;
                retire      = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a   = 2'b01;
                bus.alu_op      = 2'b01;
                pc_write_cond_r = 1'b1;
                bus.pc_source   = 2'b01;
                retire          = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write-type strobes are forced quiet while reset is held, whatever state is registered.
    assign bus.pc_write      = pc_write_r      & ~reset;
    assign bus.pc_write_cond = pc_write_cond_r & ~reset;
    assign bus.ir_write      = ir_write_r      & ~reset;
    assign bus.mem_write     = mem_write_r     & ~reset;
    assign bus.reg_write     = reg_write_r     & ~reset;
    assign bus.illegal       = illegal_r       & ~reset;
    assign bus.state         = state_q;
    assign bus.retired_count = count_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected state traces
// built from the instruction-class rules, checked cycle by cycle.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if bus();
    multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    typedef struct packed {
        logic [3:0] st;
        logic       mr;
    } step_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_count;

    // 0 = illegal, 1 = load, 2 = store, 3 = R-type, 4 = branch
    function automatic int classify(input logic [6:0] opc);
        case (opc)
            OP_LOAD:   return 1;
            OP_STORE:  return 2;
            OP_RTYPE:  return 3;
            OP_BRANCH: return 4;
            default:   return 0;
        endcase
    endfunction

    // {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, mem_to_reg,
    //  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal}
    function automatic logic [16:0] exp_out(input logic [3:0] st, input logic mr, input logic [6:0] opc);
        logic pw = 0, pwc = 0, irw = 0, mrd = 0, mwr = 0, iod = 0, m2r = 0, rw = 0, ill = 0;
        logic [1:0] sa = 0, sb = 0, aop = 0, psrc = 0;
        case (st)
            4'd0: begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            4'd1: begin sb = 2'b10; ill = (classify(opc) == 0); end
            4'd2: begin sa = 2'b01; sb = 2'b10; end
            4'd3: begin mrd = 1; iod = 1; end
            4'd4: begin rw = 1; m2r = 1; end
            4'd5: begin iod = 1; mwr = 1; end
            4'd6: begin sa = 2'b01; aop = 2'b10; end
            4'd7: begin rw = 1; end
            4'd8: begin sa = 2'b01; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            default: ;
        endcase
        return {pw, pwc, irw, mrd, mwr, iod, m2r, rw, sa, sb, aop, psrc, ill};
    endfunction

    function automatic logic [16:0] dut_out();
        return {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read, bus.mem_write,
                bus.i_or_d, bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.pc_source, bus.illegal};
    endfunction

    // Entered at a negedge: drive one cycle's inputs, check, advance to the next negedge.
    task automatic step(input logic [3:0] st, input logic mr, input logic [6:0] opc);
        logic [16:0] want;
        bus.mem_ready = mr;
        bus.opcode    = (st == 4'd1) ? opc : 7'($urandom);
        #1;
        want = exp_out(st, mr, bus.opcode);
        n_checks++;
        if (bus.state !== st) begin
            n_fail++;
            $display("FAIL state op=%b: got %0d want %0d", opc, bus.state, st);
        end
        n_checks++;
        if (dut_out() !== want) begin
            n_fail++;
            $display("FAIL outputs st=%0d op=%b: got %b want %b", st, opc, dut_out(), want);
        end
        n_checks++;
        if (bus.retired_count !== exp_count) begin
            n_fail++;
            $display("FAIL retired_count st=%0d: got %0h want %0h", st, bus.retired_count, exp_count);
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [6:0] opc, input int wf, input int wm);
        step_t q[$];
        int    cls = classify(opc);
        for (int i = 0; i < wf; i++) q.push_back('{4'd0, 1'b0});
        q.push_back('{4'd0, 1'b1});
        q.push_back('{4'd1, 1'($urandom)});
        case (cls)
            1: begin
                q.push_back('{4'd2, 1'($urandom)});
                for (int i = 0; i < wm; i++) q.push_back('{4'd3, 1'b0});
                q.push_back('{4'd3, 1'b1});
                q.push_back('{4'd4, 1'($urandom)});
            end
            2: begin
                q.push_back('{4'd2, 1'($urandom)});
                for (int i = 0; i < wm; i++) q.push_back('{4'd5, 1'b0});
                q.push_back('{4'd5, 1'b1});
            end
            3: begin
                q.push_back('{4'd6, 1'($urandom)});
                q.push_back('{4'd7, 1'($urandom)});
            end
            4: q.push_back('{4'd8, 1'($urandom)});
            default: ;
        endcase
        foreach (q[i]) step(q[i].st, q[i].mr, opc);
        if (cls != 0) exp_count = exp_count + 32'd1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode    = OP_RTYPE;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (bus.state !== 4'd0 || bus.retired_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got st=%0d cnt=%0h want 0/0", bus.state, bus.retired_count);
        end
        n_checks++;
        if ({bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.mem_write, bus.reg_write, bus.illegal} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 000000",
                     {bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.mem_write, bus.reg_write, bus.illegal});
        end
        @(negedge clk);
        reset     = 1'b0;
        exp_count = 32'd0;
    endtask

    task automatic test_directed();
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_LOAD, 0, 3);
        run_instr(OP_STORE, 0, 0);
        run_instr(OP_STORE, 1, 2);
        run_instr(OP_BRANCH, 0, 0);
        run_instr(OP_BAD, 0, 0);
        run_instr(OP_RTYPE, 2, 0);
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        exp_count = 32'd0;
        repeat (5) run_instr(OP_RTYPE, $urandom_range(0, 1), 0);
        step(4'd0, 1'b1, OP_LOAD);
        step(4'd1, 1'b1, OP_LOAD);
        step(4'd2, 1'b1, OP_LOAD);
        step(4'd3, 1'b0, OP_LOAD);
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.state !== 4'd0 || bus.retired_count !== 32'd0 || bus.reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got st=%0d cnt=%0h rw=%b want 0/0/0",
                     bus.state, bus.retired_count, bus.reg_write);
        end
        reset     = 1'b0;
        exp_count = 32'd0;
        run_instr(OP_LOAD, 0, 1);
    endtask

    task automatic test_wrap();
        bus.mem_ready = 1'b0;
        force dut.count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.count_q;
        exp_count = 32'hFFFF_FFFF;
        run_instr(OP_RTYPE, 0, 0);
        n_checks++;
        if (bus.retired_count !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap: got %0h want 0", bus.retired_count);
        end
    endtask

    task automatic test_random();
        logic [6:0] opc;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: opc = OP_LOAD;
                1: opc = OP_STORE;
                2: opc = OP_RTYPE;
                3: opc = OP_BRANCH;
                4: opc = OP_BAD;
                default: opc = 7'($urandom);
            endcase
            run_instr(opc, $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        bus.opcode    = 7'd0;
        exp_count     = 32'd0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end
endmodule
